// File: rtl/vga_capture.sv
// vga_capture: captures one VGA frame into a 1-bit-per-pixel framebuffer.
//
// Each pixel strobe (pix_en_i) samples the syncs and the pixel colour. After
// an accepted arm the block waits for the start of a new frame (vsync
// assertion). It then counts hsync deassertion edges through the vertical
// back porch and skips the horizontal back porch on every line. Each active
// pixel becomes one bit (colour != 0 means live). Every 8 pixels are packed
// into one byte (leftmost pixel = LSB), and the byte is emitted as a
// one-clock framebuffer write.
//
// Ports:
//   clk_i             system clock, rising edge
//   rst_ni            asynchronous active-low reset
//   pix_en_i          pixel strobe; sync/pixel inputs only sampled when high
//   hsync_i, vsync_i  active-low sync inputs
//   px_i[11:0]        pixel colour, nonzero = live
//   arm_i             request capture of the next full frame (level)
//   write_address_o   framebuffer byte address
//   write_value_o     packed pixel byte
//   write_enable_o    one-clock write strobe
//   busy_o            capture armed or in progress
//   done_o            one-clock pulse when a frame completes
//   frame_err_o       one-clock pulse when a frame is aborted
module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BP     = 48,
    parameter int V_BP     = 33
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pix_en_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic [11:0] px_i,
    input  logic        arm_i,
    output logic [15:0] write_address_o,
    output logic [7:0]  write_value_o,
    output logic        write_enable_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        frame_err_o
);

    localparam int HSW = $clog2(H_BP + 2);
    localparam int VSW = $clog2(V_BP + 2);
    localparam logic [9:0]     X_LAST         = 10'(H_ACTIVE - 1);
    localparam logic [8:0]     Y_LAST         = 9'(V_ACTIVE - 1);
    localparam logic [15:0]    BYTES_PER_LINE = 16'(H_ACTIVE / 8);
    localparam logic [HSW-1:0] H_BP_CNT       = HSW'(H_BP);
    localparam logic [VSW-1:0] V_BP_CNT       = VSW'(V_BP);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_VS = 3'd1,
        S_V_SKIP  = 3'd2,
        S_H_WAIT  = 3'd3,
        S_H_SKIP  = 3'd4,
        S_ACTIVE  = 3'd5,
        S_FINISH  = 3'd6
    } state_e;

    state_e         state_q, state_d;
    logic           hs_q, hs_d;
    logic           vs_q, vs_d;
    logic [9:0]     x_q, x_d;
    logic [8:0]     y_q, y_d;
    logic [VSW-1:0] vcnt_q, vcnt_d;
    logic [HSW-1:0] hcnt_q, hcnt_d;
    logic [7:0]     acc_q, acc_d;
    logic [15:0]    addr_q, addr_d;
    logic [7:0]     wval_q, wval_d;
    logic           we_q, we_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic           hs_fall_s, hs_rise_s, vs_fall_s;
    logic [7:0]     acc_set_s;

    // Sync edges are relative to the previous strobe-qualified sample.
    assign hs_fall_s = pix_en_i & hs_q & ~hsync_i;
    assign hs_rise_s = pix_en_i & ~hs_q & hsync_i;
    assign vs_fall_s = pix_en_i & vs_q & ~vsync_i;

    // Accumulator with the current pixel merged in at bit x%8.
    always_comb begin
        acc_set_s = acc_q;
        acc_set_s[x_q[2:0]] = (px_i != 12'd0);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        x_d     = x_q;
        y_d     = y_q;
        vcnt_d  = vcnt_q;
        hcnt_d  = hcnt_q;
        acc_d   = acc_q;
        addr_d  = addr_q;
        wval_d  = wval_q;
        we_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (pix_en_i) begin
            hs_d = hsync_i;
            vs_d = vsync_i;
        end else begin
            hs_d = hs_q;
            vs_d = vs_q;
        end

        case (state_q)
            S_IDLE: begin
                x_d   = 10'd0;
                y_d   = 9'd0;
                acc_d = 8'd0;
                if (arm_i) begin
                    state_d = S_WAIT_VS;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end

            // Waiting for a fresh vsync assertion guarantees that a frame
            // already running when arm arrived is never captured partially.
            S_WAIT_VS: begin
                if (vs_fall_s) begin
                    state_d = S_V_SKIP;
                    vcnt_d  = {VSW{1'b0}};
                end else begin
                    state_d = S_WAIT_VS;
                end
            end

            // Only hsync deassertions seen while vsync is already released
            // count towards the vertical back porch.
            S_V_SKIP: begin
                if (hs_rise_s && vsync_i) begin
                    if (vcnt_q == V_BP_CNT) begin
                        x_d    = 10'd0;
                        acc_d  = 8'd0;
                        hcnt_d = HSW'(1);
                        if (H_BP <= 1) begin
                            state_d = S_ACTIVE;
                        end else begin
                            state_d = S_H_SKIP;
                        end
                    end else begin
                        vcnt_d = vcnt_q + VSW'(1);
                    end
                end else begin
                    vcnt_d = vcnt_q;
                end
            end

            // The strobe carrying the hsync deassertion is itself the first
            // back-porch strobe, so the skip counter starts at 1.
            S_H_WAIT: begin
                if (vs_fall_s) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    acc_d   = 8'd0;
                end else if (hs_rise_s) begin
                    x_d    = 10'd0;
                    acc_d  = 8'd0;
                    hcnt_d = HSW'(1);
                    if (H_BP <= 1) begin
                        state_d = S_ACTIVE;
                    end else begin
                        state_d = S_H_SKIP;
                    end
                end else begin
                    state_d = S_H_WAIT;
                end
            end

            S_H_SKIP: begin
                if (vs_fall_s) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    acc_d   = 8'd0;
                end else if (pix_en_i) begin
                    if ((hcnt_q + HSW'(1)) == H_BP_CNT) begin
                        state_d = S_ACTIVE;
                    end else begin
                        hcnt_d = hcnt_q + HSW'(1);
                    end
                end else begin
                    hcnt_d = hcnt_q;
                end
            end

            // An abort on a strobe discards that strobe's pixel and any
            // partially packed byte.
            S_ACTIVE: begin
                if (vs_fall_s || hs_fall_s) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    acc_d   = 8'd0;
                end else if (pix_en_i) begin
                    acc_d = acc_set_s;
                    if (x_q[2:0] == 3'd7) begin
                        we_d   = 1'b1;
                        wval_d = acc_set_s;
                        addr_d = ({7'd0, y_q} * BYTES_PER_LINE) + {9'd0, x_q[9:3]};
                        acc_d  = 8'd0;
                    end else begin
                        we_d   = 1'b0;
                    end
                    if (x_q == X_LAST) begin
                        x_d = 10'd0;
                        if (y_q == Y_LAST) begin
                            state_d = S_FINISH;
                        end else begin
                            y_d     = y_q + 9'd1;
                            state_d = S_H_WAIT;
                        end
                    end else begin
                        x_d = x_q + 10'd1;
                    end
                end else begin
                    acc_d = acc_q;
                end
            end

            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                acc_d   = 8'd0;
            end
        endcase
    end

    // State, counters and registered outputs; reset forces an idle block
    // with both previous sync samples deasserted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            x_q     <= 10'd0;
            y_q     <= 9'd0;
            vcnt_q  <= {VSW{1'b0}};
            hcnt_q  <= {HSW{1'b0}};
            acc_q   <= 8'd0;
            addr_q  <= 16'd0;
            wval_q  <= 8'd0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vcnt_q  <= vcnt_d;
            hcnt_q  <= hcnt_d;
            acc_q   <= acc_d;
            addr_q  <= addr_d;
            wval_q  <= wval_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign write_address_o = addr_q;
    assign write_value_o   = wval_q;
    assign write_enable_o  = we_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign frame_err_o     = err_q;

endmodule
